// File: rtl/s2p_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | s2p_pkg                                                              |
// | Shared types and defaults for the serial-to-parallel link scheduler. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package s2p_pkg;

   localparam int S2P_DATA_W = 15;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_SHIFT    = 2'd1,
      ST_WAIT_RDY = 2'd2,
      ST_GAP      = 2'd3
   } state_t;

   typedef logic owner_t;

endpackage
`default_nettype wire

// File: rtl/s2p_rr_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | s2p_rr_arb                                                           |
// | Two-way round-robin arbiter; the pointer moves only on a grant.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module s2p_rr_arb
   import s2p_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       grant_en,
   output logic [1:0] grant
);

   owner_t     r_last;
   logic [1:0] w_grant;

   // On a tie the requester that did not win last time takes the grant.
   always_comb begin
      w_grant = 2'b00;
      if (grant_en) begin
         w_grant[0] = req[0] & (~req[1] | r_last);
         w_grant[1] = req[1] & (~req[0] | ~r_last);
      end
   end

   assign grant = w_grant;

   // Reset as if requester 1 won last, so requester 0 wins the first tie.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_last <= 1'b1;
      end else if (|w_grant) begin
         r_last <= w_grant[1];
      end
   end

endmodule
`default_nettype wire

// File: rtl/s2p_link_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | s2p_link_scheduler                                                   |
// | Arbitrates two requesters and shifts the winning word MSB-first onto |
// | the converter serial pins. S2P_READY_CHECK_EN adds the ready wait.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module s2p_link_scheduler
   import s2p_pkg::*;
#(
   parameter int DATA_W  = S2P_DATA_W,
   parameter int DIV     = 4,
   parameter int TIMEOUT = 64,
   parameter int GAP     = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [1:0]        req,
   input  logic [DATA_W-1:0] data0,
   input  logic [DATA_W-1:0] data1,
   output logic [1:0]        ack,
   output logic [1:0]        done,
   output logic              err,
   output logic              busy,
   output logic              ser_clk,
   output logic              ser_data,
   input  logic              ser_ready
);

   localparam int DIV_W = $clog2(DIV + 1);
   localparam int BIT_W = $clog2(DATA_W);
   localparam int GAP_W = $clog2(GAP + 1);

   localparam logic [DIV_W-1:0] c_div_last = DIV_W'(DIV - 1);
   localparam logic [BIT_W-1:0] c_bit_last = BIT_W'(DATA_W - 1);
   localparam logic [GAP_W-1:0] c_gap_last = GAP_W'(GAP - 1);

   state_t              r_state;
   owner_t              r_owner;
   logic [DATA_W-2:0]   r_shift;
   logic [DIV_W-1:0]    r_div;
   logic [BIT_W-1:0]    r_bit;
   logic [GAP_W-1:0]    r_gap;
   logic [1:0]          w_grant;
   logic [DATA_W-1:0]   w_data;

`ifdef S2P_READY_CHECK_EN
   localparam int WAIT_W = $clog2(TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] c_wait_last = WAIT_W'(TIMEOUT - 1);
   logic [WAIT_W-1:0]   r_wait;
`else
   logic                w_unused;
   assign w_unused = ser_ready & (TIMEOUT > 0);
`endif

   s2p_rr_arb u_arb (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .grant_en (r_state == ST_IDLE),
      .grant    (w_grant)
   );

   assign w_data = w_grant[1] ? data1 : data0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_owner  <= 1'b0;
         r_shift  <= '0;
         r_div    <= '0;
         r_bit    <= '0;
         r_gap    <= '0;
`ifdef S2P_READY_CHECK_EN
         r_wait   <= '0;
`endif
         ack      <= 2'b00;
         done     <= 2'b00;
         err      <= 1'b0;
         busy     <= 1'b0;
         ser_clk  <= 1'b0;
         ser_data <= 1'b0;
      end else begin
         ack  <= 2'b00;
         done <= 2'b00;
         err  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (|w_grant) begin
                  ack      <= w_grant;
                  r_owner  <= w_grant[1];
                  ser_data <= w_data[DATA_W-1];
                  r_shift  <= w_data[DATA_W-2:0];
                  r_div    <= '0;
                  r_bit    <= c_bit_last;
                  ser_clk  <= 1'b0;
                  busy     <= 1'b1;
                  r_state  <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (r_div == c_div_last) begin
                  r_div <= '0;
                  if (!ser_clk) begin
                     ser_clk <= 1'b1;
                  end else begin
                     ser_clk <= 1'b0;
                     if (r_bit == '0) begin
                        ser_data <= 1'b0;
`ifdef S2P_READY_CHECK_EN
                        r_wait   <= '0;
                        r_state  <= ST_WAIT_RDY;
`else
                        done[r_owner] <= 1'b1;
                        r_gap    <= '0;
                        r_state  <= ST_GAP;
`endif
                     end else begin
                        // Next bit goes out together with the falling edge.
                        r_bit    <= r_bit - 1'b1;
                        ser_data <= r_shift[DATA_W-2];
                        r_shift  <= {r_shift[DATA_W-3:0], 1'b0};
                     end
                  end
               end else begin
                  r_div <= r_div + 1'b1;
               end
            end
`ifdef S2P_READY_CHECK_EN
            ST_WAIT_RDY: begin
               if (ser_ready) begin
                  done[r_owner] <= 1'b1;
                  r_gap         <= '0;
                  r_state       <= ST_GAP;
               end else if (r_wait == c_wait_last) begin
                  done[r_owner] <= 1'b1;
                  err           <= 1'b1;
                  r_gap         <= '0;
                  r_state       <= ST_GAP;
               end else begin
                  r_wait <= r_wait + 1'b1;
               end
            end
`endif
            ST_GAP: begin
               if (r_gap == c_gap_last) begin
                  busy    <= 1'b0;
                  r_state <= ST_IDLE;
               end else begin
                  r_gap <= r_gap + 1'b1;
               end
            end
            default: begin
               busy    <= 1'b0;
               ser_clk <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_s2p_link_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_s2p_link_scheduler                                                |
// | Scoreboard bench with a serial converter model for the scheduler.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_s2p_link_scheduler;

   localparam int DATA_W  = 15;
   localparam int DIV     = 4;
   localparam int TIMEOUT = 64;
   localparam int GAP     = 4;
   localparam int RDY_DLY = 9;   // converter raises ready this many cycles after its 15th bit

`ifdef S2P_READY_CHECK_EN
   localparam int   LAT_NORMAL  = 126;
   localparam int   LAT_TIMEOUT = 184;
   localparam int   LAT_EARLY   = 121;
   localparam logic ERR_TIMEOUT = 1'b1;
`else
   localparam int   LAT_NORMAL  = 120;
   localparam int   LAT_TIMEOUT = 120;
   localparam int   LAT_EARLY   = 120;
   localparam logic ERR_TIMEOUT = 1'b0;
`endif

   typedef struct {
      int                owner;
      logic [DATA_W-1:0] word;
      logic              err;
      int                req_cyc;
      int                lat;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [1:0]        req = 2'b00;
   logic [DATA_W-1:0] data0 = '0;
   logic [DATA_W-1:0] data1 = '0;
   logic [1:0]        ack;
   logic [1:0]        done;
   logic              err;
   logic              busy;
   logic              ser_clk;
   logic              ser_data;
   logic              ser_ready = 1'b0;

   exp_t ack_q[$];
   exp_t done_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   rdy_mode = 0;   // 0 converter model, 1 stuck low, 2 stuck high
   int   ack_seen = 0;
   int   last_ack_cyc = -1000;
   int   last_done_cyc = -1000;
   int   rdy_at = -1;
   int   conv_cnt = 0;
   logic [DATA_W-1:0] conv_word = '0;
   logic prev_clk = 1'b0;

   s2p_link_scheduler #(
      .DATA_W  (DATA_W),
      .DIV     (DIV),
      .TIMEOUT (TIMEOUT),
      .GAP     (GAP)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .data0     (data0),
      .data1     (data1),
      .ack       (ack),
      .done      (done),
      .err       (err),
      .busy      (busy),
      .ser_clk   (ser_clk),
      .ser_data  (ser_data),
      .ser_ready (ser_ready)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic expect_frame(input int owner, input logic [DATA_W-1:0] w, input logic e,
                               input int rc, input int lat, input bit with_done);
      exp_t x;
      x.owner = owner; x.word = w; x.err = e; x.req_cyc = rc; x.lat = lat;
      ack_q.push_back(x);
      if (with_done) done_q.push_back(x);
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_acks(input int n);
      int t = 0;
      while (ack_seen < n && t < 2000) begin
         @(negedge clk);
         t++;
      end
      chk("ack_arrived", 32'(ack_seen >= n), 1);
   endtask

   task automatic wait_idle();
      int t = 0;
      while ((done_q.size() != 0 || busy) && t < 2000) begin
         @(negedge clk);
         t++;
      end
      chk("frame_completed", done_q.size(), 0);
      wait_cycles(2);
   endtask

   // Monitor and converter model: pops the scoreboard whenever the DUT pulses ack/done.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            conv_cnt  = 0;
            conv_word = '0;
            rdy_at    = -1;
         end else begin
            if (ser_clk && !prev_clk) begin
               conv_word = {conv_word[DATA_W-2:0], ser_data};
               conv_cnt++;
               if (conv_cnt == 1) chk("first_rise_cycle", cyc - last_ack_cyc, DIV);
               if (conv_cnt == DATA_W) rdy_at = cyc + RDY_DLY;
            end
            if (ack != 2'b00) begin
               if (ack_q.size() == 0) begin
                  chk("unexpected_ack", ack, 0);
               end else begin
                  e = ack_q.pop_front();
                  chk("ack_owner", ack, 1 << e.owner);
                  if (e.req_cyc >= 0) chk("ack_latency", cyc - e.req_cyc, 1);
                  else                chk("ack_after_gap", cyc - last_done_cyc, GAP + 1);
                  chk("busy_at_ack", busy, 1);
               end
               last_ack_cyc = cyc;
               ack_seen++;
               conv_cnt = 0;
            end
            if (done != 2'b00) begin
               if (done_q.size() == 0) begin
                  chk("unexpected_done", done, 0);
               end else begin
                  e = done_q.pop_front();
                  chk("done_owner", done, 1 << e.owner);
                  chk("done_err", err, e.err);
                  chk("done_latency", cyc - last_ack_cyc, e.lat);
                  chk("conv_word", conv_word, e.word);
                  chk("conv_bits", conv_cnt, DATA_W);
                  chk("ser_clk_after_shift", ser_clk, 0);
               end
               last_done_cyc = cyc;
               rdy_at = -1;
            end else if (err) begin
               chk("err_without_done", err, 0);
            end
            if (cyc == last_done_cyc + GAP - 1) chk("busy_in_gap", busy, 1);
            if (cyc == last_done_cyc + GAP)     chk("idle_after_gap", busy, 0);
         end
         case (rdy_mode)
            1:       ser_ready = 1'b0;
            2:       ser_ready = 1'b1;
            default: ser_ready = (rdy_at >= 0) && (cyc >= rdy_at);
         endcase
         prev_clk = ser_clk;
      end
   end

   initial begin : stimulus
      int t;
      rst_n = 1'b0;
      wait_cycles(3);
      chk("reset_ack", ack, 0);
      chk("reset_done", done, 0);
      chk("reset_err", err, 0);
      chk("reset_busy", busy, 0);
      chk("reset_ser_clk", ser_clk, 0);
      chk("reset_ser_data", ser_data, 0);
      rst_n = 1'b1;
      wait_cycles(2);

      // Single word from requester 0
      rdy_mode = 0;
      data0 = 15'h5A3C;
      expect_frame(0, 15'h5A3C, 1'b0, cyc, LAT_NORMAL, 1'b1);
      req = 2'b01;
      wait_acks(1);
      req = 2'b00;
      wait_idle();

      // Converter never answers
      rdy_mode = 1;
      data0 = 15'h1234;
      expect_frame(0, 15'h1234, ERR_TIMEOUT, cyc, LAT_TIMEOUT, 1'b1);
      req = 2'b01;
      wait_acks(2);
      req = 2'b00;
      wait_idle();

      // Ready stuck high during the shift
      rdy_mode = 2;
      data1 = 15'h2AAA;
      expect_frame(1, 15'h2AAA, 1'b0, cyc, LAT_EARLY, 1'b1);
      req = 2'b10;
      wait_acks(3);
      req = 2'b00;
      wait_idle();

      // Reset in the middle of a frame
      rdy_mode = 0;
      data1 = 15'h0F0F;
      expect_frame(1, 15'h0F0F, 1'b0, cyc, 0, 1'b0);
      req = 2'b10;
      wait_acks(4);
      req = 2'b00;
      t = 0;
      while (conv_cnt < 7 && t < 300) begin
         @(negedge clk);
         t++;
      end
      chk("reached_bit7", 32'(conv_cnt >= 7), 1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort_ser_clk", ser_clk, 0);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_ser_data", ser_data, 0);
      @(negedge clk);
      rst_n = 1'b1;
      wait_cycles(2);

      // Continuous contention straight after reset
      data0 = 15'h0001;
      data1 = 15'h7FFF;
      expect_frame(0, 15'h0001, 1'b0, cyc, LAT_NORMAL, 1'b1);
      expect_frame(1, 15'h7FFF, 1'b0, -1, LAT_NORMAL, 1'b1);
      expect_frame(0, 15'h0001, 1'b0, -1, LAT_NORMAL, 1'b1);
      expect_frame(1, 15'h7FFF, 1'b0, -1, LAT_NORMAL, 1'b1);
      req = 2'b11;
      wait_acks(8);
      req = 2'b00;
      wait_idle();

      chk("ack_queue_empty", ack_q.size(), 0);
      chk("idle_at_end", busy, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: got no completion, expected end of test before time limit");
      $fatal(1);
   end

endmodule
`default_nettype wire

// File: doc/s2p_link_scheduler.md
# s2p_link_scheduler

Serial link master that feeds the 15-bit serial-to-parallel converter. Two on-chip requesters submit 15-bit words. A round-robin arbiter picks one, and the block shifts it MSB-first onto the converter's serial clock/data pins. With the ready check compiled in, it then waits for the converter's data-ready before reporting completion. It is the only driver of the converter's serial inputs.

## Interface
- `DATA_W`, 15, frame width; must equal converter width.
- `DIV`, 4, `ser_clk` half-period in `clk` cycles; ≥1.
- `TIMEOUT`, 64, max `clk` cycles to wait for `ser_ready`; ≥1.
- `GAP`, 4, idle `clk` cycles between frames, `ser_clk` low; ≥1.

Ports:
- `clk`  in  1  single system clock; all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req`  in  2  per-requester request; hold with data until `ack`.
- `data0`, `data1`  in  `DATA_W` each  words for requester 0 and requester 1.
- `ack`  out  2  one-cycle pulse; data sampled that cycle.
- `done`  out  2  one-cycle pulse to the owner when its frame completes.
- `err`  out  1  valid with `done`; 1 = `ser_ready` timeout.
- `busy`  out  1  high from grant until return to IDLE.
- `ser_clk`  out  1  to converter serial clock (`ui_in[0]`).
- `ser_data`  out  1  to converter serial data (`ui_in[1]`).
- `ser_ready`  in  1  converter data-ready (`uio_out[7]`).

## Operation
- FSM states: IDLE, SHIFT, WAIT_RDY, GAP.
- **IDLE**
  - If any `req` is high, grant and load the shift register with that requester's data.
  - Pulse `ack[g]`, record the owner, enter SHIFT.
  - Round robin: if both requesters are high, grant the one not granted last. After reset, requester 0 wins the first tie.
- **SHIFT**
  - Bit index runs `DATA_W-1` down to 0.
  - Per bit: `ser_data` = current bit, stable for the whole bit. `ser_clk` is low for `DIV` cycles, then high for `DIV` cycles.
  - The converter samples on the rising edge of `ser_clk`.
  - After the high phase of bit 0: `ser_clk`=0, `ser_data`=0, enter WAIT_RDY.
- **WAIT_RDY**
  - `ser_ready` is sampled only in this state; it is ignored in SHIFT.
  - `ser_ready`=1: pulse `done[owner]` with `err`=0 and enter GAP. If `ser_ready` is already high on the first WAIT_RDY cycle, completion happens that cycle.
  - `TIMEOUT` cycles without `ser_ready`: pulse `done[owner]` with `err`=1 and enter GAP.
  - The wait counter saturates and is cleared on WAIT_RDY entry.
- **GAP**
  - Hold `ser_clk`=0 for `GAP` cycles, then return to IDLE.
  - Requests are not sampled during GAP.
- Requester behaviour:
  - A requester that drops `req` before `ack` is simply not granted.
  - `req` held high after `ack` is a new request, eligible at the next IDLE.
- Counters (divider, bit index, wait, gap) use `$clog2`-sized widths.
- `busy` = state ≠ IDLE.

## Timing
- Reset values: state=IDLE, `ser_clk`=0, `ser_data`=0, `ack`=0, `done`=0, `err`=0, `busy`=0, round-robin pointer favors requester 0.
- Reset mid-frame aborts immediately. No `done` is issued for the aborted frame, and outputs take their reset values on the next edge.
- With `req` high in IDLE at cycle N:
  - Cycle N+1: `ack` high, `busy` high, `ser_data`=bit `DATA_W-1`.
  - First `ser_clk` rise at N+1+`DIV`.
- Shift phase lasts `2*DIV*DATA_W` cycles (120 for the defaults).
- Earliest next `ack` comes `GAP`+1 cycles after `done`.
- All outputs are registered.

## Configuration
- `S2P_READY_CHECK_EN`
  - Defined: WAIT_RDY and the timeout exist as described above.
  - Undefined: WAIT_RDY and its counter are removed. SHIFT goes directly to GAP, pulsing `done[owner]` on GAP entry. `err` is constant 0 and `ser_ready` is unused.

## Structure
- Package `s2p_pkg`: state enum, `DATA_W` default, owner index type.
- Sub-module `s2p_rr_arb`: 2-way round-robin arbiter.
  - Inputs: `req`, `grant_en`.
  - Outputs: one-hot `grant`.
  - Its pointer updates only on a grant.
- Top level holds the FSM, divider, shifter and counters.

## Test plan
- Single word: `req[0]`, `data0`=15'h5A3C, converter model asserts `ser_ready` after 15 bits. Expect `ack[0]` at N+1, 15 `ser_clk` rises sampling 1,0,1,1,0,1,0,0,0,1,1,1,1,0,0, `done[0]` with `err`=0, and converter output 15'h5A3C.
- Contention: both `req` high continuously with `data0`=15'h0001 and `data1`=15'h7FFF. Grants alternate 0,1,0,1 and the `done` owners match.
- Timeout (macro defined): `ser_ready` held 0. Expect `done[0]` with `err`=1 exactly `TIMEOUT` cycles after WAIT_RDY entry, then GAP, then IDLE.
- Early ready: `ser_ready` stuck high during SHIFT. Expect no early `done`; completion on the first WAIT_RDY cycle.
- Reset mid-frame: `rst_n`=0 at bit 7. Next edge gives `ser_clk`=0, `busy`=0, no `done`; a new request afterwards is granted to requester 0.
- Macro undefined: `done` pulses `2*DIV*DATA_W` cycles after `ack`, `err` always 0.
